mem_stage: RTL and testbench

//   MEM pipeline stage directly downstream of the execute stage. Registers EX results, runs one

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-SRAM request/response bus between the MEM stage (master) and the memory side (slave).
interface mem_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, runs one data-SRAM transaction per load/store,
// aligns/extends load data and presents the M-stage result for forwarding and writeback.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter bit          KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_e,
    input  logic [31:0] aluout_e,
    input  logic [4:0]  writereg_e,
    input  logic [1:0]  ctrl_e,
    input  logic        mem_en_e,
    input  logic [5:0]  op_e,
    input  logic [31:0] wdata_e,
    input  logic [3:0]  sel_e,
    input  logic [7:0]  excode_e,
    mem_stage_if.master dbus,
    output logic        stall_mem,
    output logic [31:0] result_m,
    output logic [4:0]  writereg_m,
    output logic        regwrite_m,
    output logic [31:0] pc_m,
    output logic [7:0]  excode_m
);
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2b;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q;
    logic        discard_q;
    logic [31:0] rdata_q;
    logic [31:0] pc_q, aluout_q, wdata_q;
    logic [4:0]  writereg_q;
    logic        regwrite_q, memtoreg_q, mem_en_q;
    logic [5:0]  op_q;
    logic [3:0]  sel_q;
    logic [7:0]  excode_q;

    logic        mem_go;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            aluout_q   <= '0;
            writereg_q <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            mem_en_q   <= 1'b0;
            op_q       <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            excode_q   <= '0;
        end else if (flush) begin
            pc_q       <= RESET_PC;
            aluout_q   <= '0;
            writereg_q <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            mem_en_q   <= 1'b0;
            op_q       <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            excode_q   <= '0;
        end else if (!stall) begin
            pc_q       <= pc_e;
            aluout_q   <= aluout_e;
            writereg_q <= writereg_e;
            regwrite_q <= ctrl_e[1];
            memtoreg_q <= ctrl_e[0];
            mem_en_q   <= mem_en_e;
            op_q       <= op_e;
            wdata_q    <= wdata_e;
            sel_q      <= sel_e;
            excode_q   <= excode_e;
        end
    end

    assign mem_go = mem_en_q && (excode_q == 8'd0);

    // DONE is held while stalled so the same instruction never re-enters IDLE and reissues.
    // discard_q marks an accepted request whose instruction was flushed; its data is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_go && !flush) state_q <= StReq;
                end
                StReq: begin
                    if (dbus.data_addr_ok && dbus.data_data_ok) begin
                        if (!flush) rdata_q <= dbus.data_rdata;
                        state_q <= flush ? StIdle : StDone;
                    end else if (dbus.data_addr_ok) begin
                        state_q   <= StWait;
                        discard_q <= flush;
                    end else if (flush) begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (dbus.data_data_ok) begin
                        if (!(discard_q || flush)) rdata_q <= dbus.data_rdata;
                        state_q   <= (discard_q || flush) ? StIdle : StDone;
                        discard_q <= 1'b0;
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (flush || !stall) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_mem = ((state_q == StIdle) && mem_go) || (state_q == StReq) ||
                       (state_q == StWait);

    assign dbus.data_req   = (state_q == StReq);
    assign dbus.data_wr    = |sel_q;
    assign dbus.data_wdata = wdata_q;
    assign dbus.data_addr  = (KSEG_MAP && (aluout_q[31:30] == 2'b10)) ?
                             {3'b000, aluout_q[28:0]} : aluout_q;

    always_comb begin
        dbus.data_size = 2'd0;
        case (op_q)
            OpLw, OpSw:       dbus.data_size = 2'd2;
            OpLh, OpLhu, OpSh: dbus.data_size = 2'd1;
            default:          dbus.data_size = 2'd0;
        endcase
    end

    always_comb begin
        lane_byte = rdata_q[7:0];
        unique case (aluout_q[1:0])
            2'd0: lane_byte = rdata_q[7:0];
            2'd1: lane_byte = rdata_q[15:8];
            2'd2: lane_byte = rdata_q[23:16];
            2'd3: lane_byte = rdata_q[31:24];
            default: lane_byte = rdata_q[7:0];
        endcase
        lane_half = aluout_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_val  = rdata_q;
        case (op_q)
            OpLb:    load_val = {{24{lane_byte[7]}}, lane_byte};
            OpLbu:   load_val = {24'd0, lane_byte};
            OpLh:    load_val = {{16{lane_half[15]}}, lane_half};
            OpLhu:   load_val = {16'd0, lane_half};
            default: load_val = rdata_q;
        endcase
    end

    assign result_m   = memtoreg_q ? load_val : aluout_q;
    assign writereg_m = writereg_q;
    assign regwrite_m = regwrite_q;
    assign pc_m       = pc_q;
    assign excode_m   = excode_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a small SRAM responder, a hazard-unit stall model and a
// scoreboard of expected M-stage results.
module tb_mem_stage;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset, stall, stall_ext, flush;
    logic [31:0] pc_e, aluout_e, wdata_e;
    logic [4:0]  writereg_e;
    logic [1:0]  ctrl_e;
    logic        mem_en_e;
    logic [5:0]  op_e;
    logic [3:0]  sel_e;
    logic [7:0]  excode_e;
    logic        stall_mem, regwrite_m;
    logic [31:0] result_m, pc_m;
    logic [4:0]  writereg_m;
    logic [7:0]  excode_m;

    mem_stage_if dbus ();

    // Hazard unit: the whole pipe stalls while a transaction is outstanding.
    assign stall = stall_mem | stall_ext;

    mem_stage #(.RESET_PC(RST_PC), .KSEG_MAP(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .pc_e(pc_e), .aluout_e(aluout_e), .writereg_e(writereg_e), .ctrl_e(ctrl_e),
        .mem_en_e(mem_en_e), .op_e(op_e), .wdata_e(wdata_e), .sel_e(sel_e),
        .excode_e(excode_e), .dbus(dbus), .stall_mem(stall_mem), .result_m(result_m),
        .writereg_m(writereg_m), .regwrite_m(regwrite_m), .pc_m(pc_m), .excode_m(excode_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wreg;
        logic        rw;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble_ex();
        pc_e = '0; aluout_e = '0; writereg_e = '0; ctrl_e = '0; mem_en_e = 1'b0;
        op_e = '0; wdata_e = '0; sel_e = '0; excode_e = '0;
    endtask

    // Drives one EX instruction for a single load edge; returns at the next negedge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wr,
                         input logic [1:0] ctrl, input logic en, input logic [5:0] op,
                         input logic [31:0] wd, input logic [3:0] sel, input logic [7:0] exc,
                         input logic [31:0] exp_res);
        @(negedge clk);
        pc_e = pc; aluout_e = alu; writereg_e = wr; ctrl_e = ctrl; mem_en_e = en;
        op_e = op; wdata_e = wd; sel_e = sel; excode_e = exc;
        sb.push_back('{exp_res, wr, ctrl[1], pc});
        @(negedge clk);
        bubble_ex();
    endtask

    // Replaces the newest expectation with a flushed bubble.
    task automatic squash();
        void'(sb.pop_back());
        sb.push_back('{32'd0, 5'd0, 1'b0, RST_PC});
    endtask

    task automatic retire(input string tag);
        exp_t e;
        check({tag, " sb nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, " result_m"}, result_m, e.res);
        check({tag, " writereg_m"}, 32'(writereg_m), 32'(e.wreg));
        check({tag, " regwrite_m"}, 32'(regwrite_m), 32'(e.rw));
        check({tag, " pc_m"}, pc_m, e.pc);
    endtask

    // SRAM responder: addr_ok a_lat cycles after the first request cycle, data_ok d_lat
    // cycles after addr_ok. Returns at the negedge of the first cycle with stall_mem low.
    task automatic serve(input string tag, input int a_lat, input int d_lat,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [1:0] exp_size, input logic exp_wr,
                         input logic [31:0] exp_wdata, input int exp_stall);
        int   rq, ak, sc, extra;
        logic ok;
        rq = -1; ak = -1; sc = 0; extra = 0; ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            dbus.data_addr_ok = 1'b0;
            dbus.data_data_ok = 1'b0;
            if (rq < 0 && dbus.data_req) rq = t;
            if (ak >= 0 && dbus.data_req) extra++;
            if (rq >= 0 && ak < 0 && dbus.data_req && (t - rq) == a_lat) begin
                dbus.data_addr_ok = 1'b1;
                ak = t;
                check({tag, " data_addr"}, dbus.data_addr, exp_addr);
                check({tag, " data_size"}, 32'(dbus.data_size), 32'(exp_size));
                check({tag, " data_wr"}, 32'(dbus.data_wr), 32'(exp_wr));
                check({tag, " data_wdata"}, dbus.data_wdata, exp_wdata);
            end
            if (ak >= 0 && (t - ak) == d_lat) begin
                dbus.data_data_ok = 1'b1;
                dbus.data_rdata   = rd;
            end
            if (rq >= 0) begin
                if (stall_mem) sc++;
                else ok = 1'b1;
            end
        end
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b0;
        check({tag, " completed"}, 32'(ok), 32'd1);
        check({tag, " stall cycles"}, sc, exp_stall);
        check({tag, " reissued req"}, extra, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; stall_ext = 1'b0;
        bubble_ex();
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = '0;
        #1;
        check("rst pc_m", pc_m, RST_PC);
        check("rst data_req", 32'(dbus.data_req), 0);
        check("rst stall_mem", 32'(stall_mem), 0);
        check("rst regwrite_m", 32'(regwrite_m), 0);
        check("rst result_m", result_m, 0);
        check("rst excode_m", 32'(excode_m), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // LW in kseg1
        issue(32'hbfc00100, 32'hbfc00010, 5'd8, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h12345678);
        check("lw idle stall_mem", 32'(stall_mem), 1);
        check("lw idle data_req", 32'(dbus.data_req), 0);
        serve("lw", 0, 2, 32'h12345678, 32'h1fc00010, 2'd2, 1'b0, 32'h0, 3);
        retire("lw");

        issue(32'hbfc00104, 32'hbfc00023, 5'd9, 2'b11, 1'b1, OP_LB, 32'h0, 4'h0, 8'h0,
              32'hffffff80);
        serve("lb", 1, 1, 32'h80ffffff, 32'h1fc00023, 2'd0, 1'b0, 32'h0, 3);
        retire("lb");

        issue(32'hbfc00108, 32'hbfc00023, 5'd10, 2'b11, 1'b1, OP_LBU, 32'h0, 4'h0, 8'h0,
              32'h00000080);
        serve("lbu", 0, 0, 32'h80ffffff, 32'h1fc00023, 2'd0, 1'b0, 32'h0, 1);
        retire("lbu");

        issue(32'hbfc0010c, 32'hbfc00022, 5'd11, 2'b11, 1'b1, OP_LHU, 32'h0, 4'h0, 8'h0,
              32'h00008000);
        serve("lhu", 0, 1, 32'h80001234, 32'h1fc00022, 2'd1, 1'b0, 32'h0, 2);
        retire("lhu");

        issue(32'hbfc00110, 32'hbfc00020, 5'd12, 2'b11, 1'b1, OP_LH, 32'h0, 4'h0, 8'h0,
              32'hfffff00d);
        serve("lh", 0, 1, 32'h1234f00d, 32'h1fc00020, 2'd1, 1'b0, 32'h0, 2);
        retire("lh");

        // kuseg address is not remapped
        issue(32'hbfc00114, 32'h00401004, 5'd13, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'hcafef00d);
        serve("lw kuseg", 2, 3, 32'hcafef00d, 32'h00401004, 2'd2, 1'b0, 32'h0, 6);
        retire("lw kuseg");

        issue(32'hbfc00118, 32'hbfc00032, 5'd0, 2'b00, 1'b1, OP_SH, 32'hbeefbeef, 4'b1100,
              8'h0, 32'hbfc00032);
        serve("sh", 0, 1, 32'h0, 32'h1fc00032, 2'd1, 1'b1, 32'hbeefbeef, 2);
        retire("sh");

        // Access already carrying an exception: no bus activity
        issue(32'hbfc00200, 32'hbfc00011, 5'd9, 2'b00, 1'b1, OP_LW, 32'h0, 4'h0, 8'h20,
              32'hbfc00011);
        check("adel stall_mem", 32'(stall_mem), 0);
        check("adel data_req", 32'(dbus.data_req), 0);
        check("adel excode_m", 32'(excode_m), 32'h20);
        retire("adel");
        @(negedge clk);
        check("adel no late req", 32'(dbus.data_req), 0);

        issue(32'hbfc00300, 32'h00000abc, 5'd3, 2'b10, 1'b0, 6'h00, 32'h0, 4'h0, 8'h0,
              32'h00000abc);
        check("alu stall_mem", 32'(stall_mem), 0);
        retire("alu");

        // Flush while the request is still unaccepted
        issue(32'hbfc00400, 32'hbfc00040, 5'd14, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h0);
        @(negedge clk);
        check("flush req data_req", 32'(dbus.data_req), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush req dropped", 32'(dbus.data_req), 0);
        check("flush req stall_mem", 32'(stall_mem), 0);
        squash();
        retire("flush req");
        @(negedge clk);
        check("flush req no reissue", 32'(dbus.data_req), 0);

        // Flush while waiting for data
        issue(32'hbfc00500, 32'hbfc00050, 5'd15, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h0);
        @(negedge clk);
        dbus.data_addr_ok = 1'b1;
        @(negedge clk);
        dbus.data_addr_ok = 1'b0;
        check("flush wait data_req", 32'(dbus.data_req), 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush wait stall held", 32'(stall_mem), 1);
        check("flush wait regwrite_m", 32'(regwrite_m), 0);
        @(negedge clk);
        check("flush wait still held", 32'(stall_mem), 1);
        dbus.data_data_ok = 1'b1;
        dbus.data_rdata   = 32'hdeadbeef;
        @(negedge clk);
        dbus.data_data_ok = 1'b0;
        check("flush wait released", 32'(stall_mem), 0);
        squash();
        retire("flush wait");
        issue(32'hbfc00600, 32'hbfc00060, 5'd16, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h0badf00d);
        serve("lw after flush", 0, 1, 32'h0badf00d, 32'h1fc00060, 2'd2, 1'b0, 32'h0, 2);
        retire("lw after flush");

        // External stall while DONE keeps the loaded value and issues nothing
        issue(32'hbfc00700, 32'hbfc00070, 5'd17, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h55aa33cc);
        serve("lw stall done", 0, 0, 32'h55aa33cc, 32'h1fc00070, 2'd2, 1'b0, 32'h0, 1);
        stall_ext = 1'b1;
        dbus.data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done hold result_m", result_m, 32'h55aa33cc);
            check("done hold data_req", 32'(dbus.data_req), 0);
            check("done hold stall_mem", 32'(stall_mem), 0);
        end
        retire("lw stall done");
        stall_ext = 1'b0;

        // Asynchronous reset in the middle of a transaction
        issue(32'hbfc00800, 32'hbfc00080, 5'd18, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h0);
        @(negedge clk);
        dbus.data_addr_ok = 1'b1;
        @(negedge clk);
        dbus.data_addr_ok = 1'b0;
        check("rst wait stall_mem before", 32'(stall_mem), 1);
        #2 reset = 1'b1;
        #1;
        check("rst wait data_req", 32'(dbus.data_req), 0);
        check("rst wait stall_mem", 32'(stall_mem), 0);
        check("rst wait pc_m", pc_m, RST_PC);
        check("rst wait regwrite_m", 32'(regwrite_m), 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;

        issue(32'hbfc00900, 32'hbfc00090, 5'd19, 2'b11, 1'b1, OP_LW, 32'h0, 4'h0, 8'h0,
              32'h13579bdf);
        serve("lw after reset", 1, 0, 32'h13579bdf, 32'h1fc00090, 2'd2, 1'b0, 32'h0, 2);
        retire("lw after reset");

        check("sb drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
